tinker_fetch_unit: RTL
======================

TINKER_FETCH_UNIT -- requirements
Module: tinker_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h2000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  single-cycle instruction-read request pulse.
REQ-006 SHALL have port imem_addr  output  64  byte address of the request, valid while imem_req=1.
REQ-007 SHALL have port imem_rvalid  input  1  read data returned this cycle.
REQ-008 SHALL have port imem_rdata  input  32  little-endian instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/flush from execute (taken branch, call, return).
REQ-010 SHALL have port redirect_pc  input  64  new fetch address.
REQ-011 SHALL have port out_valid  output  1  queue head valid toward decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts head (low during load-use stall).
REQ-013 SHALL have port out_instr  output  32  head instruction word.
REQ-014 SHALL have port out_pc  output  64  head instruction address.

Function
REQ-015 SHALL hold fetch_pc, a FIFO of DEPTH {instr,pc} entries, count, and at most one outstanding request.
REQ-016 SHALL assert imem_req with imem_addr=fetch_pc when no request is outstanding, count<DEPTH (count+outstanding<=DEPTH after issue), not halted, and redirect_valid=0.
REQ-017 SHALL advance fetch_pc by 4 (modulo 2^64) on the edge where the request issues.
REQ-018 SHALL accept imem_rvalid no earlier than one cycle after the request; arbitrary further latency SHALL be tolerated.
REQ-019 SHALL push {imem_rdata, address of request} on imem_rvalid when the outstanding request is not marked drop.
REQ-020 SHALL ignore imem_rvalid when no request is outstanding.
REQ-021 SHALL present the head combinationally on out_instr/out_pc with out_valid=(count!=0) and redirect_valid=0.
REQ-022 SHALL pop the head on out_valid&&out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-023 SHALL never push when full; REQ-016 guarantees this, and an overflow SHALL be a checked assertion failure.
REQ-024 SHALL, on redirect_valid, empty the FIFO, set fetch_pc=redirect_pc, mark any outstanding request drop, clear halted, and issue no request that cycle; first request to redirect_pc is in the following cycle.
REQ-025 SHALL discard imem_rvalid arriving in the redirect cycle or for a dropped request; the drop mark clears with that response.
REQ-026 SHALL set halted when a pushed word has bits[31:27]=5'h0F and bits[3:0]=4'h0; the halt word is enqueued and delivered normally, no further requests issue until redirect.
REQ-027 SHALL make redirect win over simultaneous pop, push, and halt detection.

Reset
REQ-028 SHALL on reset asynchronously force imem_req=0, imem_addr=RESET_PC, out_valid=0, count=0, fetch_pc=RESET_PC, outstanding=0, drop=0, halted=0.
REQ-029 SHALL ignore imem_rvalid for a request issued before a reset, including reset asserted mid-request.
REQ-030 SHALL issue the first request in the first clock after reset deasserts.

Configuration
REQ-031 SHALL, when TINKER_FETCH_STATS_EN is defined, add outputs stat_fetched (32, pushed words) and stat_dropped (32, discarded responses plus FIFO entries flushed), both wrapping, reset to 0.
REQ-032 SHALL, without TINKER_FETCH_STATS_EN, omit those ports and counters; other behaviour identical.

Verification
REQ-033 Reset release, memory latency 1, out_ready=1 -> requests 0x2000,0x2004,0x2008 on consecutive request slots; out_pc sequence identical, in order.
REQ-034 out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 entries queued (0x2000..0x200C), imem_req stays 0 until a pop.
REQ-035 Redirect to 0x3000 while request 0x2008 outstanding with latency 3 -> its response discarded, out_valid=0 redirect cycle, next out_pc=0x3000; stat_dropped counts it when TINKER_FETCH_STATS_EN.
REQ-036 Word 32'h78000000 fetched at 0x2010 -> delivered with out_pc=0x2010, no request to 0x2014; redirect to 0x2000 resumes fetching.
REQ-037 Redirect, pop and imem_rvalid in the same cycle with FIFO full -> FIFO empty next cycle, fetch_pc=redirect_pc, no overflow.
REQ-038 Reset asserted between request and response, response arrives 2 cycles later -> ignored, first out_pc after release=0x2000.

Source files
------------

// File: rtl/tinker_fetch_unit.sv
// ============================================================================
//  Module      : tinker_fetch_unit
//  Description : Instruction fetch unit with a DEPTH-entry prefetch queue.
//                Issues at most one instruction-memory read at a time,
//                queues returned {instr, pc} pairs toward decode, and stops
//                fetching after a halt word until execute redirects.
//  Ports       : clk, reset (async, active-high)
//                imem_req / imem_addr         - read request pulse + address
//                imem_rvalid / imem_rdata     - read response
//                redirect_valid / redirect_pc - flush and restart fetch
//                out_valid / out_ready / out_instr / out_pc - decode side
//  Options     : define TINKER_FETCH_STATS_EN to add stat_fetched and
//                stat_dropped counters (32-bit, wrapping).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tinker_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
`ifdef TINKER_FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped
`endif
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [63:0]        r_fetchPc;
    logic [63:0]        r_reqPc;        // address of the outstanding request
    logic               r_outstanding;
    logic               r_drop;         // outstanding response must be discarded
    logic               r_halted;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [31:0]        r_fifoInstr [DEPTH];
    logic [63:0]        r_fifoPc    [DEPTH];

    logic w_issue;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_haltWord;

    // Reset gates the request combinationally so the pulse is low for the
    // whole time reset is asserted, not just after the next edge.
    assign w_issue  = !reset && !r_outstanding && (r_count < c_DEPTH) &&
                      !r_halted && !redirect_valid;
    // A response only counts against a request issued on an earlier edge.
    assign w_accept = imem_rvalid && r_outstanding;
    assign w_push   = w_accept && !r_drop && !redirect_valid;
    assign w_pop    = out_valid && out_ready;
    assign w_haltWord = (imem_rdata[31:27] == 5'h0F) && (imem_rdata[3:0] == 4'h0);

    assign imem_req  = w_issue;
    assign imem_addr = r_fetchPc;
    assign out_valid = (r_count != '0) && !redirect_valid;
    assign out_instr = r_fifoInstr[r_head];
    assign out_pc    = r_fifoPc[r_head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetchPc     <= RESET_PC;
            r_reqPc       <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_halted      <= 1'b0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            // The response closes the transaction whether kept or discarded.
            if (w_accept) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_reqPc       <= r_fetchPc;
                r_fetchPc     <= r_fetchPc + 64'd4;
            end
            if (redirect_valid) begin
                r_fetchPc <= redirect_pc;
                r_halted  <= 1'b0;
                r_count   <= '0;
                r_head    <= '0;
                r_tail    <= '0;
                if (r_outstanding && !imem_rvalid) begin
                    r_drop <= 1'b1;
                end
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_W'(1);
                    if (w_haltWord) begin
                        r_halted <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoInstr[r_tail] <= imem_rdata;
            r_fifoPc[r_tail]    <= r_reqPc;
        end
    end

    // Issue is gated on count<DEPTH with a single outstanding request, so a
    // push can never find the queue full.
    noOverflow: assert property (@(posedge clk) disable iff (reset)
                                 !(w_push && (r_count == c_DEPTH)));

`ifdef TINKER_FETCH_STATS_EN
    logic [31:0] r_statFetched;
    logic [31:0] r_statDropped;
    logic        w_discard;

    assign w_discard = w_accept && (r_drop || redirect_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_statFetched <= '0;
            r_statDropped <= '0;
        end else begin
            if (w_push) begin
                r_statFetched <= r_statFetched + 32'd1;
            end
            // Flushed queue entries and discarded responses both count.
            r_statDropped <= r_statDropped + 32'(w_discard) +
                             (redirect_valid ? 32'(r_count) : 32'd0);
        end
    end

    assign stat_fetched = r_statFetched;
    assign stat_dropped = r_statDropped;
`endif

endmodule

`default_nettype wire
